// File: rtl/btb_nway_if.sv
// Fetch-side BTB bundle: IF1 lookup, IF2 prediction, decode invalidate,
// commit install/train, and flush sweep control.
interface btb_nway_if #(
  parameter int WAY_W = 1
);
  logic             flush_i;
  logic             busy_o;
  logic             if1_valid_i;
  logic [31:0]      if1_pc_i;
  logic             btb_vld_o;
  logic [WAY_W-1:0] btb_way_o;
  logic [1:0]       btb_btype_o;
  logic [1:0]       btb_bm_pred_o;
  logic [31:0]      btb_target_o;
  logic             btb_index_o;
  logic             btb_correct_i;
  logic [31:0]      btb_correct_pc_i;
  logic [WAY_W-1:0] btb_correct_way_i;
  logic             c1_btb_mod_i;
  logic             c1_btb_bm_i;
  logic [31:0]      c1_btb_vpc_i;
  logic [31:0]      c1_btb_target_i;
  logic [1:0]       c1_cntr_pred_i;
  logic             c1_bnch_tkn_i;
  logic [1:0]       c1_bnch_type_i;
  logic             c1_bnch_present_i;
  logic [WAY_W-1:0] c1_btb_way_i;

  modport slave (
    input  flush_i, if1_valid_i, if1_pc_i,
    input  btb_correct_i, btb_correct_pc_i, btb_correct_way_i,
    input  c1_btb_mod_i, c1_btb_bm_i, c1_btb_vpc_i, c1_btb_target_i,
    input  c1_cntr_pred_i, c1_bnch_tkn_i, c1_bnch_type_i, c1_bnch_present_i,
    input  c1_btb_way_i,
    output busy_o, btb_vld_o, btb_way_o, btb_btype_o, btb_bm_pred_o,
    output btb_target_o, btb_index_o
  );

  modport master (
    output flush_i, if1_valid_i, if1_pc_i,
    output btb_correct_i, btb_correct_pc_i, btb_correct_way_i,
    output c1_btb_mod_i, c1_btb_bm_i, c1_btb_vpc_i, c1_btb_target_i,
    output c1_cntr_pred_i, c1_bnch_tkn_i, c1_bnch_type_i, c1_bnch_present_i,
    output c1_btb_way_i,
    input  busy_o, btb_vld_o, btb_way_o, btb_btype_o, btb_bm_pred_o,
    input  btb_target_o, btb_index_o
  );
endinterface

// File: rtl/btb_nway.sv
// N-way set-associative branch target buffer with registered IF2 prediction,
// single-port write arbitration and a one-set-per-cycle flush sweep.
module btb_way_match #(
  parameter int TAG_W = 12
) (
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag_st,
  input  logic [TAG_W-1:0] i_tag_lk,
  input  logic             i_idx,
  input  logic             i_pc2,
  input  logic             i_chk_slot,
  output logic             o_hit
);
  // A stored slot-0 branch is behind a fetch that starts at slot 1.
  assign o_hit = i_valid && (i_tag_st == i_tag_lk) && !(i_chk_slot && !i_idx && i_pc2);
endmodule

module btb_nway #(
  parameter int SETS  = 32,
  parameter int WAYS  = 2,
  parameter int TAG_W = 12
) (
  input logic      cpu_clk_i,
  input logic      reset_ni,
  btb_nway_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int HI_W  = 32 - 3 - IDX_W;

  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  typedef struct packed {
    logic [1:0]  btype;
    logic [1:0]  cntr;
    logic [29:0] tgt;
    logic        idx;
  } ent_t;

  function automatic logic [IDX_W-1:0] f_set(input logic [31:0] pc);
    return pc[3 +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(input logic [31:0] pc);
    logic [TAG_W-1:0] t;
    t = '0;
    for (int i = 0; i < HI_W; i++) t[i % TAG_W] = t[i % TAG_W] ^ pc[3+IDX_W+i];
    return t;
  endfunction

  function automatic logic [1:0] f_cnt(input logic [1:0] p, input logic tkn);
    if (tkn) return (p == 2'd3) ? 2'd3 : p + 2'd1;
    return (p == 2'd0) ? 2'd0 : p - 2'd1;
  endfunction

  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAY_W-1:0] r_vptr  [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  ent_t             r_ent   [SETS][WAYS];

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;

  logic             r_vld, r_idx;
  logic [WAY_W-1:0] r_way;
  logic [1:0]       r_btype, r_bm;
  logic [29:0]      r_tgt;

  logic [IDX_W-1:0] w_lk_set, w_c1_set, w_cr_set;
  logic [TAG_W-1:0] w_lk_tag, w_c1_tag;
  logic [WAYS-1:0]  w_lk_hitv, w_c1_hitv;
  logic             w_lk_hit, w_c1_hit, w_any_inv, w_lk_fire, w_busy;
  logic [WAY_W-1:0] w_lk_way, w_c1_hit_way, w_inv_way, w_c1_way, w_vptr_nxt;
  logic             w_do_mod, w_do_cor, w_do_bm;
  logic [1:0]       w_cnt_upd;
  ent_t             w_lk_ent;
  logic             w_unused;

  assign w_lk_set = f_set(bus.if1_pc_i);
  assign w_lk_tag = f_tag(bus.if1_pc_i);
  assign w_c1_set = f_set(bus.c1_btb_vpc_i);
  assign w_c1_tag = f_tag(bus.c1_btb_vpc_i);
  assign w_cr_set = f_set(bus.btb_correct_pc_i);
  assign w_unused = ^{bus.if1_pc_i[1:0], bus.c1_btb_vpc_i[1:0], bus.c1_btb_target_i[1:0],
                      bus.btb_correct_pc_i};

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    btb_way_match #(.TAG_W(TAG_W)) u_lk (
      .i_valid    (r_valid[w_lk_set][w]),
      .i_tag_st   (r_tag[w_lk_set][w]),
      .i_tag_lk   (w_lk_tag),
      .i_idx      (r_ent[w_lk_set][w].idx),
      .i_pc2      (bus.if1_pc_i[2]),
      .i_chk_slot (1'b1),
      .o_hit      (w_lk_hitv[w])
    );
    btb_way_match #(.TAG_W(TAG_W)) u_c1 (
      .i_valid    (r_valid[w_c1_set][w]),
      .i_tag_st   (r_tag[w_c1_set][w]),
      .i_tag_lk   (w_c1_tag),
      .i_idx      (r_ent[w_c1_set][w].idx),
      .i_pc2      (bus.c1_btb_vpc_i[2]),
      .i_chk_slot (1'b0),
      .o_hit      (w_c1_hitv[w])
    );
  end

  // Downward scans so the lowest matching way is the one left standing.
  always_comb begin
    w_lk_hit     = 1'b0;
    w_lk_way     = '0;
    w_c1_hit     = 1'b0;
    w_c1_hit_way = '0;
    w_any_inv    = 1'b0;
    w_inv_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_lk_hitv[w]) begin
        w_lk_hit = 1'b1;
        w_lk_way = WAY_W'(w);
      end
      if (w_c1_hitv[w]) begin
        w_c1_hit     = 1'b1;
        w_c1_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_c1_set][w]) begin
        w_any_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign w_vptr_nxt = (r_vptr[w_c1_set] == WAY_W'(WAYS - 1)) ? '0 : r_vptr[w_c1_set] + 1'b1;
  assign w_c1_way   = w_c1_hit ? w_c1_hit_way : (w_any_inv ? w_inv_way : r_vptr[w_c1_set]);
  assign w_cnt_upd  = f_cnt(bus.c1_cntr_pred_i, bus.c1_bnch_tkn_i);

  assign w_busy   = (r_state == S_SWEEP);
  assign w_do_mod = bus.c1_btb_mod_i && !w_busy;
  assign w_do_cor = bus.btb_correct_i && !bus.c1_btb_mod_i && !w_busy;
  assign w_do_bm  = bus.c1_btb_bm_i && !bus.btb_correct_i && !bus.c1_btb_mod_i && !w_busy;

  always_ff @(posedge cpu_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (bus.flush_i) begin
        w_state_nxt = S_SWEEP;
        w_cnt_nxt   = '0;
      end
      S_SWEEP: begin
        if (bus.flush_i) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == IDX_W'(SETS - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Valid bits and victim pointers carry reset; the sweep owns them while busy.
  always_ff @(posedge cpu_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_vptr[s]  <= '0;
      end
    end else if (w_busy) begin
      r_valid[r_cnt] <= '0;
      r_vptr[r_cnt]  <= '0;
    end else if (w_do_mod) begin
      r_valid[w_c1_set][w_c1_way] <= bus.c1_bnch_present_i;
      if (!w_c1_hit && !w_any_inv) r_vptr[w_c1_set] <= w_vptr_nxt;
    end else if (w_do_cor) begin
      r_valid[w_cr_set][bus.btb_correct_way_i] <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clk_i) begin
    if (w_do_mod) begin
      r_ent[w_c1_set][w_c1_way] <= '{btype: bus.c1_bnch_type_i,
                                     cntr:  bus.c1_bnch_present_i ? w_cnt_upd : 2'd0,
                                     tgt:   bus.c1_btb_target_i[31:2],
                                     idx:   bus.c1_btb_vpc_i[2]};
      if (!w_c1_hit) r_tag[w_c1_set][w_c1_way] <= w_c1_tag;
    end else if (w_do_bm) begin
      r_ent[w_c1_set][bus.c1_btb_way_i].cntr <= w_cnt_upd;
    end
  end

  assign w_lk_fire = bus.if1_valid_i && !bus.c1_btb_mod_i && !w_busy && w_lk_hit;
  assign w_lk_ent  = r_ent[w_lk_set][w_lk_way];

  always_ff @(posedge cpu_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_vld   <= 1'b0;
      r_way   <= '0;
      r_btype <= '0;
      r_bm    <= '0;
      r_tgt   <= '0;
      r_idx   <= 1'b0;
    end else begin
      r_vld <= w_lk_fire;
      if (w_lk_fire) begin
        r_way   <= w_lk_way;
        r_btype <= w_lk_ent.btype;
        r_bm    <= w_lk_ent.cntr;
        r_tgt   <= w_lk_ent.tgt;
        r_idx   <= w_lk_ent.idx;
      end
    end
  end

  assign bus.busy_o        = w_busy;
  assign bus.btb_vld_o     = r_vld;
  assign bus.btb_way_o     = r_way;
  assign bus.btb_btype_o   = r_btype;
  assign bus.btb_bm_pred_o = r_bm;
  assign bus.btb_target_o  = {r_tgt, 2'b00};
  assign bus.btb_index_o   = r_idx;
endmodule

// File: tb/tb_btb_nway.sv
// Randomised scoreboard bench for btb_nway against a set/way array model.
module tb_btb_nway;
  localparam int SETS  = 32;
  localparam int WAYS  = 2;
  localparam int TAG_W = 12;
  localparam int IDX_W = 5;
  localparam int WAY_W = 1;
  localparam int OUT_W = 1 + WAY_W + 2 + 2 + 32 + 1;

  logic cpu_clk_i = 1'b0;
  logic reset_ni  = 1'b0;
  always #5 cpu_clk_i = ~cpu_clk_i;

  btb_nway_if #(.WAY_W(WAY_W)) bus ();

  btb_nway #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .cpu_clk_i (cpu_clk_i),
    .reset_ni  (reset_ni),
    .bus       (bus)
  );

  typedef struct {
    logic             flush, lv, cor, mod, bm, tkn, pres;
    logic [31:0]      lpc, cpc, vpc, tgt;
    logic [WAY_W-1:0] cway, bway;
    logic [1:0]       pred, typ;
  } stim_t;

  typedef struct {
    int               cyc;
    logic [OUT_W-1:0] out;
    logic             busy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge cpu_clk_i) cyc <= cyc + 1;

  // Reference state: one record per (set, way) plus a round-robin pointer per set.
  bit         m_val [SETS][WAYS];
  int         m_tag [SETS][WAYS];
  bit [1:0]   m_bt  [SETS][WAYS];
  bit [1:0]   m_cn  [SETS][WAYS];
  bit [31:0]  m_tg  [SETS][WAYS];
  bit         m_ix  [SETS][WAYS];
  int         m_vptr[SETS];
  bit         m_sweep = 1'b0;
  int         m_swset = 0;
  logic [OUT_W-1:0] m_out = '0;

  function automatic int mset(input logic [31:0] pc);
    return int'((pc >> 3) % SETS);
  endfunction

  function automatic int mtag(input logic [31:0] pc);
    int t;
    logic [31:0] h;
    t = 0;
    h = pc >> (3 + IDX_W);
    while (h != 0) begin
      t = t ^ int'(h % (1 << TAG_W));
      h = h >> TAG_W;
    end
    return t;
  endfunction

  function automatic bit [1:0] mupd(input logic [1:0] p, input logic tkn);
    int v;
    v = tkn ? int'(p) + 1 : int'(p) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  function automatic logic [31:0] rpc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 3) |
           (32'($urandom_range(0, 1)) << 2);
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s.flush = 0; s.lv = 0; s.cor = 0; s.mod = 0; s.bm = 0; s.tkn = 0; s.pres = 0;
    s.lpc = '0; s.cpc = '0; s.vpc = '0; s.tgt = '0;
    s.cway = '0; s.bway = '0; s.pred = '0; s.typ = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = nop();
    s.lv   = ($urandom_range(0, 9) < 7);
    s.lpc  = rpc();
    s.cor  = ($urandom_range(0, 9) == 0);
    s.cpc  = rpc();
    s.cway = WAY_W'($urandom);
    s.mod  = ($urandom_range(0, 3) == 0);
    s.bm   = ($urandom_range(0, 4) == 0);
    s.vpc  = rpc();
    s.tgt  = $urandom & 32'hFFFF_FFFC;
    s.pred = 2'($urandom);
    s.tkn  = 1'($urandom);
    s.typ  = 2'($urandom);
    s.pres = ($urandom_range(0, 7) != 0);
    s.bway = WAY_W'($urandom);
    return s;
  endfunction

  task automatic model(input stim_t s);
    int ls, lt, hw, cs, ct, w;
    bit hit;
    exp_t e;
    ls = mset(s.lpc);
    lt = mtag(s.lpc);
    hit = 0;
    hw = 0;
    for (int k = WAYS - 1; k >= 0; k--)
      if (m_val[ls][k] && m_tag[ls][k] == lt && !(m_ix[ls][k] == 0 && s.lpc[2])) begin
        hit = 1;
        hw  = k;
      end
    if (s.lv && !s.mod && !m_sweep && hit)
      m_out = {1'b1, WAY_W'(hw), m_bt[ls][hw], m_cn[ls][hw], m_tg[ls][hw], m_ix[ls][hw]};
    else
      m_out[OUT_W-1] = 1'b0;

    if (!m_sweep) begin
      if (s.mod) begin
        cs = mset(s.vpc);
        ct = mtag(s.vpc);
        w = -1;
        for (int k = 0; k < WAYS; k++)
          if (w < 0 && m_val[cs][k] && m_tag[cs][k] == ct) w = k;
        if (w < 0) begin
          for (int k = 0; k < WAYS; k++)
            if (w < 0 && !m_val[cs][k]) w = k;
          if (w < 0) begin
            w = m_vptr[cs];
            m_vptr[cs] = (m_vptr[cs] + 1) % WAYS;
          end
          m_tag[cs][w] = ct;
        end
        m_val[cs][w] = s.pres;
        m_bt[cs][w]  = s.typ;
        m_cn[cs][w]  = s.pres ? mupd(s.pred, s.tkn) : 2'd0;
        m_tg[cs][w]  = s.tgt & 32'hFFFF_FFFC;
        m_ix[cs][w]  = s.vpc[2];
      end else if (s.cor) begin
        m_val[mset(s.cpc)][int'(s.cway)] = 0;
      end else if (s.bm) begin
        m_cn[mset(s.vpc)][int'(s.bway)] = mupd(s.pred, s.tkn);
      end
    end

    if (m_sweep) begin
      for (int k = 0; k < WAYS; k++) m_val[m_swset][k] = 0;
      m_vptr[m_swset] = 0;
    end
    if (s.flush) begin
      m_sweep = 1;
      m_swset = 0;
    end else if (m_sweep) begin
      if (m_swset == SETS - 1) m_sweep = 0;
      else m_swset++;
    end

    e.cyc  = cyc;
    e.out  = m_out;
    e.busy = m_sweep;
    q.push_back(e);
  endtask

  task automatic step(input stim_t s);
    @(posedge cpu_clk_i);
    #1;
    bus.flush_i           = s.flush;
    bus.if1_valid_i       = s.lv;
    bus.if1_pc_i          = s.lpc;
    bus.btb_correct_i     = s.cor;
    bus.btb_correct_pc_i  = s.cpc;
    bus.btb_correct_way_i = s.cway;
    bus.c1_btb_mod_i      = s.mod;
    bus.c1_btb_bm_i       = s.bm;
    bus.c1_btb_vpc_i      = s.vpc;
    bus.c1_btb_target_i   = s.tgt;
    bus.c1_cntr_pred_i    = s.pred;
    bus.c1_bnch_tkn_i     = s.tkn;
    bus.c1_bnch_type_i    = s.typ;
    bus.c1_bnch_present_i = s.pres;
    bus.c1_btb_way_i      = s.bway;
    model(s);
  endtask

  task automatic monitor();
    exp_t e;
    logic [OUT_W-1:0] got;
    forever begin
      @(negedge cpu_clk_i);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        got = {bus.btb_vld_o, bus.btb_way_o, bus.btb_btype_o, bus.btb_bm_pred_o,
               bus.btb_target_o, bus.btb_index_o};
        n_cmp++;
        if (got !== e.out) begin
          n_bad++;
          $display("FAIL pred cyc=%0d got=%h exp=%h", e.cyc, got, e.out);
        end
        n_cmp++;
        if (bus.busy_o !== e.busy) begin
          n_bad++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, bus.busy_o, e.busy);
        end
      end
    end
  endtask

  task automatic install(input logic [31:0] vpc, input logic [31:0] tgt, input logic [1:0] typ,
                         input logic [1:0] pred, input logic tkn);
    stim_t s;
    s = nop();
    s.mod = 1; s.vpc = vpc; s.tgt = tgt; s.typ = typ; s.pred = pred; s.tkn = tkn; s.pres = 1;
    step(s);
  endtask

  task automatic lookup(input logic [31:0] pc);
    stim_t s;
    s = nop();
    s.lv = 1; s.lpc = pc;
    step(s);
  endtask

  initial begin
    stim_t s;
    logic [OUT_W+0:0] rst_got;
    s = nop();
    step(s);
    void'(q.pop_back());
    fork
      monitor();
    join_none
    reset_ni = 1'b0;
    repeat (3) begin
      @(negedge cpu_clk_i);
      rst_got = {bus.btb_vld_o, bus.btb_way_o, bus.btb_btype_o, bus.btb_bm_pred_o,
                 bus.btb_target_o, bus.btb_index_o, bus.busy_o};
      n_cmp++;
      if (rst_got !== '0) begin
        n_bad++;
        $display("FAIL reset got=%h exp=0", rst_got);
      end
    end
    @(posedge cpu_clk_i);
    #1 reset_ni = 1'b1;

    lookup(32'h0000_1008);
    install(32'h0000_1008, 32'h0000_2000, 2'b10, 2'b01, 1'b1);
    lookup(32'h0000_1008);
    lookup(32'h0000_100C);
    install(32'h0000_2000, 32'h0000_3000, 2'b00, 2'b10, 1'b0);
    lookup(32'h0000_2004);
    lookup(32'h0000_2000);

    for (int k = 1; k <= 4; k++) begin
      install((32'(k) << 8) | 32'h8, 32'(k) << 12, 2'(k), 2'b01, 1'b0);
      for (int j = 0; j <= 4; j++) lookup((32'(j) << 8) | 32'h8);
      lookup(32'h0000_1008);
    end

    s = nop(); s.bm = 1; s.vpc = 32'h2000; s.pred = 2'b11; s.tkn = 1; step(s);
    lookup(32'h0000_2000);
    s = nop(); s.bm = 1; s.vpc = 32'h2000; s.pred = 2'b00; s.tkn = 0; step(s);
    lookup(32'h0000_2000);
    s = nop(); s.mod = 1; s.bm = 1; s.vpc = 32'h2000; s.tgt = 32'h3000; s.pres = 1;
    s.pred = 2'b00; s.tkn = 1; step(s);
    lookup(32'h0000_2000);

    s = nop(); s.flush = 1; step(s);
    for (int i = 0; i < 50; i++) begin
      s = rnd();
      s.flush = (i == 9);
      s.lv = 1;
      if (i % 2 == 0) s.lpc = 32'h0000_2000;
      step(s);
    end
    for (int st = 0; st < SETS; st++) begin
      lookup((32'($urandom_range(0, 4)) << 8) | (32'(st) << 3));
      lookup((32'(st) << 3) | 32'h4);
    end

    for (int i = 0; i < 900; i++) begin
      s = rnd();
      s.flush = ($urandom_range(0, 199) == 0);
      step(s);
    end

    s = nop();
    step(s);
    for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge cpu_clk_i);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
